phase_bus_responder: RTL

PHASE_BUS_RESPONDER -- requirements
Module: phase_bus_responder

---
 rtl/phase_bus_pkg.sv | 31 +++
 rtl/phase_bus_responder_if.sv | 20 ++
 rtl/phase_bus_adc_ctrl.sv | 57 +++++
 rtl/phase_bus_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/phase_bus_pkg.sv
// Shared definitions for the phase bus: port map, strobe levels and FSM state types.
// Used by both the responder card and the bus master.
package phase_bus_pkg;

    localparam logic [2:0] PORT_LAMP0  = 3'd0;
    localparam logic [2:0] PORT_LAMP1  = 3'd1;
    localparam logic [2:0] PORT_LAMP2  = 3'd2;
    localparam logic [2:0] PORT_MUX    = 3'd3;
    localparam logic [2:0] PORT_ADC_HI = 3'd4;
    localparam logic [2:0] PORT_ADC_LO = 3'd5;
    localparam logic [2:0] PORT_STATUS = 3'd6;
    localparam logic [2:0] PORT_ID     = 3'd7;

    typedef enum logic {
        STROBE_ACTIVE = 1'b0,
        STROBE_IDLE   = 1'b1
    } strobe_e;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_WRITE,
        BUS_READ,
        BUS_ERROR
    } bus_state_e;

    typedef enum logic {
        ADC_IDLE,
        ADC_CONVERTING
    } adc_state_e;

endpackage

// File: rtl/phase_bus_responder_if.sv
// Asynchronous card-bus signals shared between the master and a responder card.
interface phase_bus_responder_if;
    logic [3:0] BOARD_X;
    logic [2:0] AddessPortPin;
    logic       RdP;
    logic       WrP;
    logic [7:0] Data_In_Port;
    logic [7:0] Data_Out_Port;
    logic       data_oe;

    modport master (
        output BOARD_X, AddessPortPin, RdP, WrP, Data_In_Port,
        input  Data_Out_Port, data_oe
    );

    modport slave (
        input  BOARD_X, AddessPortPin, RdP, WrP, Data_In_Port,
        output Data_Out_Port, data_oe
    );
endinterface

// File: rtl/phase_bus_adc_ctrl.sv
// ADC conversion sequencer: waits CONV_CYCLES cycles after a start, then captures the sample.
// A start while converting restarts the count; an abort leaves the last result intact.
module phase_bus_adc_ctrl
    import phase_bus_pkg::*;
#(
    parameter int CONV_CYCLES = 270
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [15:0] i_value,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_result
);
    localparam int            CW   = $clog2(CONV_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CONV_CYCLES - 1);

    adc_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_result;
    logic          w_latch;

    always_ff @(posedge clock) begin
        if (reset) r_state <= ADC_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        if (i_abort) begin
            w_state_nxt = ADC_IDLE;
        end else if (i_start) begin
            w_state_nxt = ADC_CONVERTING;
        end else if (r_state == ADC_CONVERTING && r_cnt == LAST) begin
            w_state_nxt = ADC_IDLE;
            w_latch     = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (i_start)                       r_cnt <= '0;
            else if (r_state == ADC_CONVERTING) r_cnt <= r_cnt + CW'(1);
            if (w_latch) r_result <= i_value;
        end
    end

    assign o_busy   = (r_state == ADC_CONVERTING);
    assign o_done   = w_latch;
    assign o_result = r_result;
endmodule

// File: rtl/phase_bus_responder.sv
// Phase-control card responder: eight byte ports on the asynchronous card bus, three
// lamp latches, an ADC mux/result pair, status and a fixed card ID.
module phase_bus_responder
    import phase_bus_pkg::*;
#(
    parameter int         BOARD_INDEX = 0,
    parameter int         CONV_CYCLES = 270,
    parameter logic [7:0] CARD_ID     = 8'hA5
) (
    input  logic                   clock,
    input  logic                   reset,
    phase_bus_responder_if.slave   bus,
    input  logic                   LampResetPin,
    output logic [23:0]            lamp_out,
    output logic [7:0]             adc_channel,
    input  logic [15:0]            adc_value,
    output logic                   adc_busy
);
    localparam logic [1:0] SEL_BIT = 2'(BOARD_INDEX);

    logic [1:0]      r_rd_s, r_wr_s, r_lrst_s;
    logic [1:0][3:0] r_bx_s;
    logic [1:0][2:0] r_addr_s;
    logic [1:0][7:0] r_din_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_s   <= {STROBE_IDLE, STROBE_IDLE};
            r_wr_s   <= {STROBE_IDLE, STROBE_IDLE};
            r_lrst_s <= '0;
            r_bx_s   <= '0;
            r_addr_s <= '0;
            r_din_s  <= '0;
        end else begin
            r_rd_s   <= {r_rd_s[0], bus.RdP};
            r_wr_s   <= {r_wr_s[0], bus.WrP};
            r_lrst_s <= {r_lrst_s[0], LampResetPin};
            r_bx_s   <= {r_bx_s[0], bus.BOARD_X};
            r_addr_s <= {r_addr_s[0], bus.AddessPortPin};
            r_din_s  <= {r_din_s[0], bus.Data_In_Port};
        end
    end

    logic       w_rd_act, w_wr_act, w_sel, w_lrst, w_both;
    logic [2:0] w_addr;
    logic [7:0] w_din;

    assign w_rd_act = (r_rd_s[1] == STROBE_ACTIVE);
    assign w_wr_act = (r_wr_s[1] == STROBE_ACTIVE);
    assign w_sel    = r_bx_s[1][SEL_BIT];
    assign w_lrst   = r_lrst_s[1];
    assign w_addr   = r_addr_s[1];
    assign w_din    = r_din_s[1];
    assign w_both   = w_sel && w_rd_act && w_wr_act;

    bus_state_e r_state, w_state_nxt;
    logic       w_do_write, w_rd_done, w_err_set;

    always_ff @(posedge clock) begin
        if (reset) r_state <= BUS_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_write  = 1'b0;
        w_rd_done   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            BUS_IDLE: begin
                if (w_both) begin
                    w_state_nxt = BUS_ERROR;
                    w_err_set   = 1'b1;
                end else if (w_sel && w_wr_act) w_state_nxt = BUS_WRITE;
                else if (w_sel && w_rd_act)     w_state_nxt = BUS_READ;
            end
            BUS_WRITE: begin
                if (w_both) begin
                    w_state_nxt = BUS_ERROR;
                    w_err_set   = 1'b1;
                end else if (!w_wr_act) begin
                    w_state_nxt = BUS_IDLE;
                    w_do_write  = 1'b1;
                end
            end
            BUS_READ: begin
                if (w_both) begin
                    w_state_nxt = BUS_ERROR;
                    w_err_set   = 1'b1;
                end else if (!w_rd_act) begin
                    w_state_nxt = BUS_IDLE;
                    w_rd_done   = 1'b1;
                end else if (!w_sel) begin
                    w_state_nxt = BUS_IDLE;
                end
            end
            BUS_ERROR: if (!w_rd_act && !w_wr_act) w_state_nxt = BUS_IDLE;
            default:   w_state_nxt = BUS_IDLE;
        endcase
    end

    logic [2:0][7:0] r_lamp;
    logic [7:0]      r_mux, r_dout, w_port;
    logic            r_err, r_done, r_oe;
    logic            w_adc_start, w_adc_done;
    logic [15:0]     w_adc_result;

    // A card reset wins over a simultaneous mux write, so no conversion starts then.
    assign w_adc_start = w_do_write && (w_addr == PORT_MUX) && !w_lrst;

    phase_bus_adc_ctrl #(.CONV_CYCLES(CONV_CYCLES)) u_adc (
        .clock    (clock),
        .reset    (reset),
        .i_start  (w_adc_start),
        .i_abort  (w_lrst),
        .i_value  (adc_value),
        .o_busy   (adc_busy),
        .o_done   (w_adc_done),
        .o_result (w_adc_result)
    );

    always_comb begin
        w_port = 8'h00;
        case (w_addr)
            PORT_LAMP0:  w_port = r_lamp[0];
            PORT_LAMP1:  w_port = r_lamp[1];
            PORT_LAMP2:  w_port = r_lamp[2];
            PORT_MUX:    w_port = r_mux;
            PORT_ADC_HI: w_port = w_adc_result[15:8];
            PORT_ADC_LO: w_port = w_adc_result[7:0];
            PORT_STATUS: w_port = {5'b0, r_err, r_done, adc_busy};
            PORT_ID:     w_port = CARD_ID;
            default:     w_port = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lamp <= '0;
            r_mux  <= '0;
            r_err  <= 1'b0;
            r_done <= 1'b0;
            r_oe   <= 1'b0;
            r_dout <= '0;
        end else begin
            if (w_lrst) begin
                r_lamp <= '0;
                r_mux  <= '0;
            end else if (w_do_write) begin
                case (w_addr)
                    PORT_LAMP0: r_lamp[0] <= w_din;
                    PORT_LAMP1: r_lamp[1] <= w_din;
                    PORT_LAMP2: r_lamp[2] <= w_din;
                    PORT_MUX:   r_mux     <= w_din;
                    default: ;
                endcase
            end
            if (w_err_set)                               r_err <= 1'b1;
            else if (w_rd_done && w_addr == PORT_STATUS) r_err <= 1'b0;
            if (w_adc_done)                              r_done <= 1'b1;
            else if (w_rd_done && w_addr == PORT_STATUS) r_done <= 1'b0;
            // Drive follows the next state so release happens one cycle after the strobe rises.
            r_oe   <= (w_state_nxt == BUS_READ);
            r_dout <= (w_state_nxt == BUS_READ) ? w_port : 8'h00;
        end
    end

    assign bus.data_oe       = r_oe;
    assign bus.Data_Out_Port = r_dout;
    assign lamp_out          = r_lamp;
    assign adc_channel       = r_mux;
endmodule
